// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: grants word-addressed fetch requests and
// returns the addressed word (or a NOP on error) after LATENCY cycles.
// The backing store is a word RAM written through a dedicated load port.
module instr_mem_responder #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned LATENCY  = 1,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_req_ip,
    input  logic [31:0]       instr_addr_ip,
    output logic              instr_gnt_op,
    output logic              instr_rvalid_op,
    output logic [31:0]       instr_rdata_op,
    output logic              instr_err_op,
    input  logic              load_we_ip,
    input  logic [ADDR_W-1:0] load_addr_ip,
    input  logic [31:0]       load_data_ip
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WIDX_W = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  word_q;
    logic               err_q;

    logic               accept_c;
    logic               addr_err_c;
    logic [ADDR_W-1:0]  fetch_idx_c;
    logic               resp_err_c;
    logic [DATA_W-1:0]  resp_data_c;

    // Word index and error classification of the presented address; the
    // range compare uses the full upper address so wrapped indices still fail.
    assign fetch_idx_c = instr_addr_ip[ADDR_W+1:2];
    assign addr_err_c  = (instr_addr_ip[1:0] != 2'b00)
                       || ({1'b0, instr_addr_ip[31:2]} >= WIDX_W'(DEPTH));

    // Grant is combinational: only in IDLE and never while reset is held.
    assign instr_gnt_op = (state_q == IDLE) && instr_req_ip && !reset;
    assign accept_c     = instr_gnt_op;

    // Next-state, latency counter and response source selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_err_c  = err_q;
        resp_data_c = word_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    resp_err_c  = addr_err_c;
                    resp_data_c = mem[fetch_idx_c];
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counter and captured error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_c) begin
                err_q <= addr_err_c;
            end
        end
    end

    // Synchronous RAM read at the accept edge; erroring requests skip the read.
    always_ff @(posedge clock) begin
        if (accept_c && !addr_err_c) begin
            word_q <= mem[fetch_idx_c];
        end
    end

    // Load port write; active in every state, reset included.
    always_ff @(posedge clock) begin
        if (load_we_ip) begin
            mem[load_addr_ip] <= load_data_ip;
        end
    end

    // Registered response: one-cycle rvalid, data held until the next response.
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_rvalid_op <= 1'b0;
            instr_rdata_op  <= '0;
            instr_err_op    <= 1'b0;
        end else begin
            instr_rvalid_op <= (state_d == RESP);
            instr_err_op    <= (state_d == RESP) && resp_err_c;
            if (state_d == RESP) begin
                instr_rdata_op <= resp_err_c ? NOP_WORD : resp_data_c;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances (LATENCY 1, 4, 3) sharing the
// load bus, checked against a transaction-level RAM/latency model.
module tb_instr_mem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  err;
    logic [31:0] addr   [3];
    logic [31:0] rdata  [3];
    logic        load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] ref_mem   [256];
    logic [31:0] last_data [3];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    instr_mem_responder #(.LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset),
        .instr_req_ip(req[0]), .instr_addr_ip(addr[0]),
        .instr_gnt_op(gnt[0]), .instr_rvalid_op(rvalid[0]),
        .instr_rdata_op(rdata[0]), .instr_err_op(err[0]),
        .load_we_ip(load_we), .load_addr_ip(load_addr), .load_data_ip(load_data)
    );

    instr_mem_responder #(.LATENCY(4)) u_lat4 (
        .clock(clock), .reset(reset),
        .instr_req_ip(req[1]), .instr_addr_ip(addr[1]),
        .instr_gnt_op(gnt[1]), .instr_rvalid_op(rvalid[1]),
        .instr_rdata_op(rdata[1]), .instr_err_op(err[1]),
        .load_we_ip(load_we), .load_addr_ip(load_addr), .load_data_ip(load_data)
    );

    instr_mem_responder #(.LATENCY(3)) u_lat3 (
        .clock(clock), .reset(reset),
        .instr_req_ip(req[2]), .instr_addr_ip(addr[2]),
        .instr_gnt_op(gnt[2]), .instr_rvalid_op(rvalid[2]),
        .instr_rdata_op(rdata[2]), .instr_err_op(err[2]),
        .load_we_ip(load_we), .load_addr_ip(load_addr), .load_data_ip(load_data)
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Write one word through the load port; returns at the following negedge.
    task automatic load(input logic [7:0] idx, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = idx;
        load_data = data;
        @(posedge clock);
        #1;
        load_we      = 1'b0;
        ref_mem[idx] = data;
        @(negedge clock);
    endtask

    // Present a request, wait for grant, optionally load in the accept cycle,
    // then check the response timing and payload. Leaves req held high.
    task automatic fetch(input int d, input logic [31:0] a, input bit ld,
                         input logic [7:0] li, input logic [31:0] ldata,
                         output int waited);
        logic        exp_err;
        logic [31:0] exp_data;
        int          lat;
        lat     = lat_of(d);
        req[d]  = 1'b1;
        addr[d] = a;
        waited  = 0;
        #1;
        while (gnt[d] !== 1'b1 && waited < 40) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("grant", 32'(gnt[d]), 32'd1);
        if (gnt[d] !== 1'b1) begin
            req[d] = 1'b0;
            return;
        end
        exp_err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        exp_data = exp_err ? NOP : ref_mem[a[9:2]];
        if (ld) begin
            load_we   = 1'b1;
            load_addr = li;
            load_data = ldata;
        end
        @(posedge clock);
        #1;
        if (ld) begin
            load_we     = 1'b0;
            ref_mem[li] = ldata;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            check("gnt_busy", 32'(gnt[d]), 32'd0);
            check("rvalid", 32'(rvalid[d]), (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) begin
                check("rdata", rdata[d], exp_data);
                check("err", 32'(err[d]), 32'(exp_err));
                last_data[d] = exp_data;
            end else begin
                check("err_low", 32'(err[d]), 32'd0);
            end
        end
    endtask

    // Drop req and check the response was a single pulse with data held.
    task automatic release_req(input int d);
        req[d] = 1'b0;
        @(negedge clock);
        check("rvalid_pulse", 32'(rvalid[d]), 32'd0);
        check("err_after", 32'(err[d]), 32'd0);
        check("rdata_hold", rdata[d], last_data[d]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        int          d;
        int          kind;
        logic [31:0] a;
        bit          ld;
        logic [7:0]  li;

        reset     = 1'b1;
        req       = '0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]      = '0;
            last_data[i] = '0;
        end

        // Preload RAM while reset is held; a request during reset is never granted.
        @(negedge clock);
        req[0] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load(8'(i), $urandom);
        end
        load(8'd0, 32'h0050_0093);
        load(8'd1, 32'h00A0_0113);
        load(8'd2, 32'h0020_81B3);
        load(8'd3, 32'h0000_0013);
        #1;
        check("gnt_in_reset", 32'(gnt[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rst_rvalid", 32'(rvalid[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
        end
        req[0] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // LATENCY=1 back-to-back fetches: grant every other cycle.
        fetch(0, 32'h0, 1'b0, 8'd0, 32'd0, w);
        check("first_wait", 32'(w), 32'd0);
        check("word0", rdata[0], 32'h0050_0093);
        fetch(0, 32'h4, 1'b0, 8'd0, 32'd0, w);
        check("b2b_wait", 32'(w), 32'd1);
        check("word1", rdata[0], 32'h00A0_0113);
        fetch(0, 32'h8, 1'b0, 8'd0, 32'd0, w);
        check("b2b_wait", 32'(w), 32'd1);
        fetch(0, 32'hC, 1'b0, 8'd0, 32'd0, w);
        check("b2b_wait", 32'(w), 32'd1);
        release_req(0);

        // LATENCY=4 with held request.
        fetch(1, 32'h4, 1'b0, 8'd0, 32'd0, w);
        check("lat4_word", rdata[1], 32'h00A0_0113);
        release_req(1);

        // Misaligned and out-of-range requests return NOP with err.
        fetch(0, 32'h6, 1'b0, 8'd0, 32'd0, w);
        release_req(0);
        fetch(0, 32'h0000_0400, 1'b0, 8'd0, 32'd0, w);
        check("oor_nop", rdata[0], NOP);
        release_req(0);

        // Same-edge load and accept: old word returned, new word afterwards.
        fetch(0, 32'h4, 1'b1, 8'd1, 32'hDEAD_BEEF, w);
        check("rbw_old", rdata[0], 32'h00A0_0113);
        release_req(0);
        fetch(0, 32'h4, 1'b0, 8'd0, 32'd0, w);
        check("rbw_new", rdata[0], 32'hDEAD_BEEF);
        release_req(0);

        // Reset during WAIT aborts the LATENCY=3 request; RAM survives.
        req[2]  = 1'b1;
        addr[2] = 32'h8;
        #1;
        check("abort_gnt", 32'(gnt[2]), 32'd1);
        @(posedge clock);
        #1;
        req[2] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) last_data[i] = '0;
        check("abort_rdata", rdata[2], 32'd0);
        check("abort_err", 32'(err[2]), 32'd0);
        check("abort_gnt_low", 32'(gnt[2]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("abort_rvalid", 32'(rvalid[2]), 32'd0);
            @(negedge clock);
        end
        fetch(2, 32'h0, 1'b0, 8'd0, 32'd0, w);
        check("abort_idle", 32'(w), 32'd0);
        check("ram_kept", rdata[2], 32'h0050_0093);
        release_req(2);

        // Randomized fetches across instances with interleaved loads.
        for (int n = 0; n < 60; n++) begin
            d    = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            end else if (kind == 1) begin
                a = {30'($urandom_range(32'h3FFF_FFFF, 256)), 2'($urandom_range(0, 3))};
            end else begin
                a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if ($urandom_range(0, 3) == 0) begin
                load(8'($urandom_range(0, 255)), $urandom);
            end
            ld = ($urandom_range(0, 4) == 0);
            li = ($urandom_range(0, 1) == 0) ? a[9:2] : 8'($urandom_range(0, 255));
            fetch(d, a, ld, li, $urandom, w);
            check("rand_wait", 32'(w), 32'd0);
            release_req(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
